// File: rtl/rx_backend_if.sv
//==============================================================================
// Module      : rx_backend_if
// Description : Signal bundle between the UART receive front-end / register
//               file and the receive back-end FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface rx_backend_if #(
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  // Control register fields and front-end frame delivery
  logic            cr_ds_i;
  logic [1:0]      cr_p_i;
  logic            cr_s_i;
  logic [10:0]     frame_i;
  logic            parity_err_i;
  logic            frame_valid_i;

  // Register-file side of the FIFO
  logic [7:0]      rx_data_o;
  logic            rx_pe_o;
  logic            rx_fe_o;
  logic            rx_brk_o;
  logic            rx_valid_o;
  logic            rx_full_o;
  logic [c_CW-1:0] rx_count_o;
  logic            rx_read_i;
  logic            overrun_o;
  logic            overrun_clear_i;

  // The back-end itself
  modport slave (
    input  cr_ds_i, cr_p_i, cr_s_i, frame_i, parity_err_i, frame_valid_i,
    input  rx_read_i, overrun_clear_i,
    output rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o, rx_full_o,
    output rx_count_o, overrun_o
  );

  // Front-end / register file driving the back-end
  modport master (
    output cr_ds_i, cr_p_i, cr_s_i, frame_i, parity_err_i, frame_valid_i,
    output rx_read_i, overrun_clear_i,
    input  rx_data_o, rx_pe_o, rx_fe_o, rx_brk_o, rx_valid_o, rx_full_o,
    input  rx_count_o, overrun_o
  );

endinterface

`default_nettype wire

// File: rtl/rx_backend.sv
//==============================================================================
// Module      : rx_backend
// Description : UART receive back-end. Decodes data, framing error and break
//               from an aligned frame and queues them with the parity error in
//               a small FIFO; sticky overrun flag on dropped frames.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rx_backend #(
  parameter int DEPTH = 4
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  rx_backend_if.slave   bus
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  // Frame field decode
  logic [3:0]      w_s0;
  logic [3:0]      w_s1;
  logic [10:0]     w_low_mask;
  logic [7:0]      w_data;
  logic            w_fe;
  logic            w_brk;
  logic [10:0]     w_entry;

  // FIFO state
  logic [10:0]     r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overrun;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_wr;
  logic            w_drop;
  logic [10:0]     w_head;

  // Decode the frame using the control fields in effect on the push cycle
  always_comb begin
    w_s0       = 4'd7 + {3'b000, bus.cr_ds_i} + {3'b000, |bus.cr_p_i};
    w_s1       = w_s0 + 4'd1;
    // Bits below the first stop bit: data plus optional parity
    w_low_mask = (11'd1 << w_s0) - 11'd1;
    w_data     = bus.cr_ds_i ? bus.frame_i[7:0] : {1'b0, bus.frame_i[6:0]};
    w_fe       = ~bus.frame_i[w_s0] | (bus.cr_s_i & ~bus.frame_i[w_s1]);
    w_brk      = w_fe & ((bus.frame_i & w_low_mask) == 11'd0);
    w_entry    = {w_brk, w_fe, bus.parity_err_i, w_data};
  end

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.rx_read_i & ~w_empty;
  // A simultaneous pop frees the slot, so a push on a full FIFO still lands
  assign w_wr    = bus.frame_valid_i & (~w_full | w_pop);
  assign w_drop  = bus.frame_valid_i & w_full & ~w_pop;

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_wr) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.overrun_clear_i) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_head          = r_mem[r_rd_ptr];
  assign bus.rx_data_o   = w_head[7:0];
  assign bus.rx_pe_o     = w_head[8];
  assign bus.rx_fe_o     = w_head[9];
  assign bus.rx_brk_o    = w_head[10];
  assign bus.rx_valid_o  = ~w_empty;
  assign bus.rx_full_o   = w_full;
  assign bus.rx_count_o  = r_count;
  assign bus.overrun_o   = r_overrun;

endmodule

`default_nettype wire
